// File: rtl/shadow_stack_if.sv
// Request/response bundle between the shadow-register controller and the shadow-stack responder.
// Signal names are taken from the responder's view: store port 0 and two-phase load port 1.
interface shadow_stack_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned INDEX_WIDTH = 12,
   parameter int unsigned TAG_WIDTH   = 20,
   parameter int unsigned ID_WIDTH    = 1
);

   logic                   st_req_i;
   logic [INDEX_WIDTH-1:0] st_index_i;
   logic [TAG_WIDTH-1:0]   st_tag_i;
   logic [XLEN-1:0]        st_wdata_i;
   logic [XLEN/8-1:0]      st_be_i;
   logic                   st_gnt_o;

   logic                   ld_req_i;
   logic [INDEX_WIDTH-1:0] ld_index_i;
   logic [ID_WIDTH-1:0]    ld_id_i;
   logic                   ld_gnt_o;
   logic                   ld_tag_valid_i;
   logic [TAG_WIDTH-1:0]   ld_tag_i;
   logic                   ld_kill_i;
   logic                   ld_rvalid_o;
   logic [XLEN-1:0]        ld_rdata_o;
   logic [ID_WIDTH-1:0]    ld_rid_o;

   modport master (
      output st_req_i, st_index_i, st_tag_i, st_wdata_i, st_be_i,
      input  st_gnt_o,
      output ld_req_i, ld_index_i, ld_id_i, ld_tag_valid_i, ld_tag_i, ld_kill_i,
      input  ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_rid_o
   );

   modport slave (
      input  st_req_i, st_index_i, st_tag_i, st_wdata_i, st_be_i,
      output st_gnt_o,
      input  ld_req_i, ld_index_i, ld_id_i, ld_tag_valid_i, ld_tag_i, ld_kill_i,
      output ld_gnt_o, ld_rvalid_o, ld_rdata_o, ld_rid_o
   );

endinterface

// File: rtl/shadow_stack_responder.sv
// Single-port SRAM scratchpad answering a write-only store port and a two-phase (G/T/R) load port.
// Optional per-byte parity storage and checking is enabled by defining SHADOW_STACK_PARITY_EN.
module shadow_stack_responder #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_WORDS   = 64,
   parameter int unsigned INDEX_WIDTH = 12,
   parameter int unsigned TAG_WIDTH   = 20,
   parameter int unsigned ID_WIDTH    = 1,
   parameter logic [TAG_WIDTH+INDEX_WIDTH-1:0] BASE_ADDR = 32'h0000_1000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   shadow_stack_if.slave     bus,
   output logic              range_err_o
`ifdef SHADOW_STACK_PARITY_EN
   ,
   output logic              par_err_o,
   output logic              par_sticky_o
`endif
);

   localparam int unsigned AW      = TAG_WIDTH + INDEX_WIDTH;
   localparam int unsigned NB      = XLEN / 8;
   localparam int unsigned OFF_LSB = $clog2(NB);
   localparam int unsigned WAW     = $clog2(NUM_WORDS);

   // Unsigned wrap makes addresses below the base land far above NUM_WORDS.
   function automatic logic addr_hit(input logic [AW-1:0] addr);
      logic [AW-1:0] rel;
      rel = addr - BASE_ADDR;
      return (rel >> OFF_LSB) < AW'(NUM_WORDS);
   endfunction

   function automatic logic [WAW-1:0] addr_word(input logic [AW-1:0] addr);
      logic [AW-1:0] rel;
      rel = (addr - BASE_ADDR) >> OFF_LSB;
      return rel[WAW-1:0];
   endfunction

   logic [XLEN-1:0]        mem_q [NUM_WORDS];

   logic                   t_vld_q;
   logic [INDEX_WIDTH-1:0] t_index_q;
   logic [ID_WIDTH-1:0]    t_id_q;
   logic                   r_vld_q;
   logic [ID_WIDTH-1:0]    r_id_q;
   logic [XLEN-1:0]        r_data_q;
   logic                   st_starve_q;
   logic                   range_err_q;

   logic                   ld_gnt;
   logic                   st_gnt;
   logic                   rd_en;
   logic                   rd_hit;
   logic                   wr_en;
   logic                   wr_hit;
   logic [AW-1:0]          rd_addr;
   logic [AW-1:0]          wr_addr;
   logic [WAW-1:0]         rd_word;
   logic [WAW-1:0]         wr_word;
   logic [XLEN-1:0]        rd_data;

   always_comb begin
      // A tag-phase read owns the SRAM; a refused store blocks the next load grant.
      st_gnt  = bus.st_req_i & ~t_vld_q;
      ld_gnt  = bus.ld_req_i & ~st_starve_q;
      rd_en   = t_vld_q & bus.ld_tag_valid_i & ~bus.ld_kill_i;
      rd_addr = {bus.ld_tag_i, t_index_q};
      wr_addr = {bus.st_tag_i, bus.st_index_i};
      rd_hit  = addr_hit(rd_addr);
      wr_hit  = addr_hit(wr_addr);
      rd_word = addr_word(rd_addr);
      wr_word = addr_word(wr_addr);
      wr_en   = st_gnt & wr_hit;
      rd_data = rd_hit ? mem_q[rd_word] : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         t_vld_q     <= 1'b0;
         t_index_q   <= '0;
         t_id_q      <= '0;
         r_vld_q     <= 1'b0;
         r_id_q      <= '0;
         r_data_q    <= '0;
         st_starve_q <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         t_vld_q     <= ld_gnt;
         if (ld_gnt) begin
            t_index_q <= bus.ld_index_i;
            t_id_q    <= bus.ld_id_i;
         end
         r_vld_q     <= rd_en;
         if (rd_en) begin
            r_id_q   <= t_id_q;
            r_data_q <= rd_data;
         end
         st_starve_q <= bus.st_req_i & ~st_gnt;
         if ((rd_en && !rd_hit) || (st_gnt && !wr_hit)) begin
            range_err_q <= 1'b1;
         end
      end
   end

   // Storage is deliberately left without reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.st_be_i[b]) begin
               mem_q[wr_word][8*b +: 8] <= bus.st_wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign bus.st_gnt_o    = st_gnt;
   assign bus.ld_gnt_o    = ld_gnt;
   assign bus.ld_rvalid_o = r_vld_q;
   assign bus.ld_rdata_o  = r_data_q;
   assign bus.ld_rid_o    = r_id_q;
   assign range_err_o     = range_err_q;

`ifdef SHADOW_STACK_PARITY_EN
   logic [NB-1:0] par_q [NUM_WORDS];
   logic [NB-1:0] wr_par;
   logic [NB-1:0] rd_par_calc;
   logic          par_mismatch;
   logic          par_err_q;
   logic          par_sticky_q;

   always_comb begin
      wr_par      = '0;
      rd_par_calc = '0;
      for (int b = 0; b < NB; b++) begin
         wr_par[b]      = ^bus.st_wdata_i[8*b +: 8];
         rd_par_calc[b] = ^mem_q[rd_word][8*b +: 8];
      end
      par_mismatch = rd_en & rd_hit & (|(rd_par_calc ^ par_q[rd_word]));
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.st_be_i[b]) begin
               par_q[wr_word][b] <= wr_par[b];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         par_err_q    <= 1'b0;
         par_sticky_q <= 1'b0;
      end else begin
         par_err_q <= par_mismatch;
         if (par_mismatch) begin
            par_sticky_q <= 1'b1;
         end
      end
   end

   assign par_err_o    = par_err_q;
   assign par_sticky_o = par_sticky_q;
`endif

endmodule
